// File: rtl/br_pkg.sv
// Shared types and constants for EX-stage branch resolution.
package br_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } funct3_e;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } br_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_redirect_if.sv
// EX-stage branch/jump operands in, fetch PC, flush, trap and counters out.
interface branch_redirect_if #(
    parameter int CNT_W = 32
);
    logic             i_stall;
    logic             i_ex_valid;
    logic             i_is_branch;
    logic             i_is_jal;
    logic             i_is_jalr;
    logic [2:0]       i_funct3;
    logic [31:0]      i_pc_ex;
    logic [31:0]      i_imm_ex;
    logic [31:0]      i_rs1_data;
    logic             i_br_less;
    logic             i_br_equal;
    logic             i_trap_ack;
    logic             o_br_un;
    logic [31:0]      o_pc;
    logic [31:0]      o_link;
    logic             o_flush;
    logic             o_trap;
    logic [31:0]      o_mepc;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_taken_cnt;

    modport master (
        output i_stall, i_ex_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
               i_pc_ex, i_imm_ex, i_rs1_data, i_br_less, i_br_equal, i_trap_ack,
        input  o_br_un, o_pc, o_link, o_flush, o_trap, o_mepc, o_br_cnt, o_taken_cnt
    );

    modport slave (
        input  i_stall, i_ex_valid, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
               i_pc_ex, i_imm_ex, i_rs1_data, i_br_less, i_br_equal, i_trap_ack,
        output o_br_un, o_pc, o_link, o_flush, o_trap, o_mepc, o_br_cnt, o_taken_cnt
    );
endinterface

// File: rtl/br_cond.sv
// Conditional-branch decode: funct3 plus comparator flags to taken/legal.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module br_cond
    import br_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       less,
    input  logic       equal,
    input  logic       is_branch,
    output logic       taken,
    output logic       legal
);

    logic cond;

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            BEQ:         cond = equal;
            BNE:         cond = ~equal;
            BLT, BLTU:   cond = less;
            BGE, BGEU:   cond = ~less;
            default:     legal = 1'b0;
        endcase
    end

    assign taken = is_branch & legal & cond;

endmodule

// File: rtl/branch_redirect.sv
// EX-stage branch resolution, fetch-PC owner, flush sequencer and misalign trap.
// Latency: redirect lands on o_pc one edge after the EX decision; o_link/o_br_un combinational.
// Backpressure: i_stall freezes every register; the EX instruction is re-evaluated afterwards.
module branch_redirect
    import br_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    branch_redirect_if.slave bus
);

    br_state_e        state;
    logic [31:0]      pc_q;
    logic [31:0]      mepc_q;
    logic             trap_q;
    logic [1:0]       flush_cnt;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    logic        sel_jalr;
    logic        sel_jal;
    logic        sel_cond;
    logic        cond_taken;
    logic        cond_legal;
    logic        ev;
    logic        taken;
    logic        misaligned;
    logic [31:0] target;

    // JALR outranks JAL, which outranks a conditional branch.
    assign sel_jalr = bus.i_is_jalr;
    assign sel_jal  = bus.i_is_jal & ~bus.i_is_jalr;
    assign sel_cond = bus.i_is_branch & ~bus.i_is_jal & ~bus.i_is_jalr;

    br_cond u_cond (
        .funct3    (bus.i_funct3),
        .less      (bus.i_br_less),
        .equal     (bus.i_br_equal),
        .is_branch (sel_cond),
        .taken     (cond_taken),
        .legal     (cond_legal)
    );

    always_comb begin
        target = bus.i_pc_ex + bus.i_imm_ex;
        if (sel_jalr) begin
            target = (bus.i_rs1_data + bus.i_imm_ex) & ~32'h1;
        end
    end

    assign ev         = bus.i_ex_valid & ~bus.i_stall & (flush_cnt == 2'd0) & (state == RUN);
    assign taken      = sel_jalr | sel_jal | cond_taken;
    // No compressed support, so any nonzero low bit is a fault.
    assign misaligned = taken & (target[1] | target[0]);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= RUN;
            pc_q      <= RESET_PC;
            mepc_q    <= 32'h0;
            trap_q    <= 1'b0;
            flush_cnt <= 2'd0;
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (!bus.i_stall) begin
            if (flush_cnt != 2'd0) begin
                flush_cnt <= flush_cnt - 2'd1;
            end

            if (ev && sel_cond && cond_legal) begin
                br_cnt <= br_cnt + 1'b1;
                if (cond_taken) begin
                    taken_cnt <= taken_cnt + 1'b1;
                end
            end

            case (state)
                RUN: begin
                    if (ev && taken && !misaligned) begin
                        pc_q      <= target;
                        flush_cnt <= 2'(FLUSH_CYCLES);
                    end else if (ev && taken && misaligned) begin
                        pc_q      <= TRAP_VEC;
                        mepc_q    <= bus.i_pc_ex;
                        trap_q    <= 1'b1;
                        flush_cnt <= 2'(FLUSH_CYCLES);
                        state     <= TRAP;
                    end else begin
                        pc_q <= pc_q + PC_STEP;
                    end
                end
                TRAP: begin
                    if (bus.i_trap_ack) begin
                        trap_q <= 1'b0;
                        pc_q   <= TRAP_VEC + PC_STEP;
                        state  <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.o_br_un     = bus.i_funct3[1];
    assign bus.o_link      = bus.i_pc_ex + PC_STEP;
    assign bus.o_pc        = pc_q;
    assign bus.o_flush     = (flush_cnt != 2'd0);
    assign bus.o_trap      = trap_q;
    assign bus.o_mepc      = mepc_q;
    assign bus.o_br_cnt    = br_cnt;
    assign bus.o_taken_cnt = taken_cnt;

endmodule

// File: tb/tb_branch_redirect.sv
// Directed scoreboard bench: driver pushes hand-computed post-edge state, monitor checks after each edge.
module tb_branch_redirect;

    typedef struct {
        logic        reset;
        logic        stall;
        logic        valid;
        logic        is_br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic [31:0] pc_ex;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        less;
        logic        eq;
        logic        ack;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        trap;
        logic [31:0] mepc;
        logic [31:0] bc;
        logic [31:0] tc;
        logic        chk_comb;
        logic [31:0] link;
        logic        br_un;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_redirect_if #(.CNT_W(32)) bif ();

    branch_redirect #(
        .RESET_PC     (32'h0000_0000),
        .TRAP_VEC     (32'h0000_0100),
        .FLUSH_CYCLES (2),
        .CNT_W        (32)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bif.slave)
    );

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic stim_t idle(input logic reset, input logic stall, input logic ack);
        stim_t s;
        s = '{reset: reset, stall: stall, valid: 1'b0, is_br: 1'b0, jal: 1'b0, jalr: 1'b0,
              f3: 3'd0, pc_ex: 32'h0, imm: 32'h0, rs1: 32'h0, less: 1'b0, eq: 1'b0, ack: ack};
        return s;
    endfunction

    function automatic stim_t br(input logic stall, input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [2:0] f3, input logic less, input logic eq);
        stim_t s;
        s = idle(1'b0, stall, 1'b0);
        s.valid = 1'b1; s.is_br = 1'b1; s.f3 = f3; s.pc_ex = pc; s.imm = imm;
        s.less = less; s.eq = eq;
        return s;
    endfunction

    function automatic stim_t jmp(input logic is_jalr, input logic [31:0] pc,
                                  input logic [31:0] rs1, input logic [31:0] imm);
        stim_t s;
        s = idle(1'b0, 1'b0, 1'b0);
        s.valid = 1'b1; s.jal = ~is_jalr; s.jalr = is_jalr;
        s.pc_ex = pc; s.rs1 = rs1; s.imm = imm;
        return s;
    endfunction

    function automatic exp_t ex(input logic [31:0] pc, input logic fl, input logic tr,
                                input logic [31:0] mepc, input logic [31:0] bc, input logic [31:0] tc);
        exp_t e;
        e = '{pc: pc, flush: fl, trap: tr, mepc: mepc, bc: bc, tc: tc,
              chk_comb: 1'b0, link: 32'h0, br_un: 1'b0};
        return e;
    endfunction

    function automatic exp_t exc(input exp_t base, input logic [31:0] link, input logic br_un);
        exp_t e;
        e = base; e.chk_comb = 1'b1; e.link = link; e.br_un = br_un;
        return e;
    endfunction

    task automatic cyc(input stim_t s, input exp_t e);
        @(negedge clk);
        rst             = s.reset;
        bif.i_stall     = s.stall;
        bif.i_ex_valid  = s.valid;
        bif.i_is_branch = s.is_br;
        bif.i_is_jal    = s.jal;
        bif.i_is_jalr   = s.jalr;
        bif.i_funct3    = s.f3;
        bif.i_pc_ex     = s.pc_ex;
        bif.i_imm_ex    = s.imm;
        bif.i_rs1_data  = s.rs1;
        bif.i_br_less   = s.less;
        bif.i_br_equal  = s.eq;
        bif.i_trap_ack  = s.ack;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            #1;
            chk("pc",        bif.o_pc, e.pc);
            chk("flush",     {31'd0, bif.o_flush}, {31'd0, e.flush});
            chk("trap",      {31'd0, bif.o_trap}, {31'd0, e.trap});
            chk("mepc",      bif.o_mepc, e.mepc);
            chk("br_cnt",    bif.o_br_cnt, e.bc);
            chk("taken_cnt", bif.o_taken_cnt, e.tc);
            if (e.chk_comb) begin
                chk("link",  bif.o_link, e.link);
                chk("br_un", {31'd0, bif.o_br_un}, {31'd0, e.br_un});
            end
        end
    end

    initial begin
        rst = 1'b1;
        bif.i_stall = 1'b0; bif.i_ex_valid = 1'b0; bif.i_is_branch = 1'b0;
        bif.i_is_jal = 1'b0; bif.i_is_jalr = 1'b0; bif.i_funct3 = 3'd0;
        bif.i_pc_ex = 32'h0; bif.i_imm_ex = 32'h0; bif.i_rs1_data = 32'h0;
        bif.i_br_less = 1'b0; bif.i_br_equal = 1'b0; bif.i_trap_ack = 1'b0;

        // reset, then free-running fetch
        cyc(idle(1, 0, 0), ex(32'h0, 0, 0, 32'h0, 0, 0));
        cyc(idle(1, 0, 0), ex(32'h0, 0, 0, 32'h0, 0, 0));
        cyc(idle(0, 0, 0), ex(32'h4, 0, 0, 32'h0, 0, 0));
        cyc(idle(0, 0, 0), ex(32'h8, 0, 0, 32'h0, 0, 0));

        // BEQ taken, then a taken-looking branch inside the flush window is ignored
        cyc(br(0, 32'h40, 32'h20, 3'b000, 0, 1), exc(ex(32'h60, 1, 0, 32'h0, 1, 1), 32'h44, 0));
        cyc(br(0, 32'h80, 32'h100, 3'b000, 0, 1), ex(32'h64, 1, 0, 32'h0, 1, 1));
        cyc(br(0, 32'h80, 32'h100, 3'b000, 0, 1), ex(32'h68, 0, 0, 32'h0, 1, 1));

        // BGEU not taken, funct3=010 ignored, BNE taken backwards
        cyc(br(0, 32'h68, 32'h40, 3'b111, 1, 0), exc(ex(32'h6C, 0, 0, 32'h0, 2, 1), 32'h6C, 1));
        cyc(br(0, 32'h6C, 32'h40, 3'b010, 1, 1), ex(32'h70, 0, 0, 32'h0, 2, 1));
        cyc(br(0, 32'h70, 32'hFFFF_FFF8, 3'b001, 0, 0), ex(32'h68, 1, 0, 32'h0, 3, 2));

        // stall in the middle of the flush
        cyc(idle(0, 1, 0), ex(32'h68, 1, 0, 32'h0, 3, 2));
        cyc(idle(0, 1, 0), ex(32'h68, 1, 0, 32'h0, 3, 2));
        cyc(idle(0, 1, 0), ex(32'h68, 1, 0, 32'h0, 3, 2));
        cyc(idle(0, 0, 0), ex(32'h6C, 1, 0, 32'h0, 3, 2));
        cyc(idle(0, 0, 0), ex(32'h70, 0, 0, 32'h0, 3, 2));

        // stalled branch re-evaluated once stall drops
        cyc(br(1, 32'h70, 32'h10, 3'b000, 0, 1), ex(32'h70, 0, 0, 32'h0, 3, 2));
        cyc(br(0, 32'h70, 32'h10, 3'b000, 0, 1), ex(32'h80, 1, 0, 32'h0, 4, 3));
        cyc(idle(0, 0, 0), ex(32'h84, 1, 0, 32'h0, 4, 3));
        cyc(idle(0, 0, 0), ex(32'h88, 0, 0, 32'h0, 4, 3));

        // misaligned JALR trap, held until an unstalled ack
        cyc(jmp(1, 32'h88, 32'h1003, 32'h0), exc(ex(32'h100, 1, 1, 32'h88, 4, 3), 32'h8C, 0));
        cyc(idle(0, 0, 0), ex(32'h100, 1, 1, 32'h88, 4, 3));
        cyc(idle(0, 0, 0), ex(32'h100, 0, 1, 32'h88, 4, 3));
        cyc(jmp(0, 32'h100, 32'h0, 32'h40), ex(32'h100, 0, 1, 32'h88, 4, 3));
        cyc(idle(0, 1, 1), ex(32'h100, 0, 1, 32'h88, 4, 3));
        cyc(idle(0, 0, 1), ex(32'h104, 0, 0, 32'h88, 4, 3));
        cyc(idle(0, 0, 0), ex(32'h108, 0, 0, 32'h88, 4, 3));

        // JAL wrapping past 2^32, then aligned JALR with bit 0 cleared
        cyc(jmp(0, 32'hFFFF_FFF0, 32'h0, 32'h20), exc(ex(32'h10, 1, 0, 32'h88, 4, 3), 32'hFFFF_FFF4, 0));
        cyc(idle(0, 0, 0), ex(32'h14, 1, 0, 32'h88, 4, 3));
        cyc(idle(0, 0, 0), ex(32'h18, 0, 0, 32'h88, 4, 3));
        cyc(jmp(1, 32'h18, 32'h2001, 32'h10), ex(32'h2010, 1, 0, 32'h88, 4, 3));
        cyc(idle(0, 0, 0), ex(32'h2014, 1, 0, 32'h88, 4, 3));
        cyc(idle(0, 0, 0), ex(32'h2018, 0, 0, 32'h88, 4, 3));

        // taken BLT to a halfword target traps and still counts
        cyc(br(0, 32'h2018, 32'h6, 3'b100, 1, 0), ex(32'h100, 1, 1, 32'h2018, 5, 4));

        // reset aborts trap and flush together
        cyc(idle(1, 0, 0), ex(32'h0, 0, 0, 32'h0, 0, 0));
        cyc(idle(0, 0, 0), ex(32'h4, 0, 0, 32'h0, 0, 0));
        cyc(br(0, 32'h4, 32'h100, 3'b110, 0, 1), exc(ex(32'h8, 0, 0, 32'h0, 1, 0), 32'h8, 1));
        cyc(br(0, 32'h8, 32'h100, 3'b101, 0, 0), ex(32'h108, 1, 0, 32'h0, 2, 1));

        cyc(idle(0, 0, 0), ex(32'h10C, 1, 0, 32'h0, 2, 1));
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
